pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, giving the program-counter payload width.
REQ-002 The block SHALL have parameter INSTR_W, default 32, giving the instruction payload width.
REQ-003 The block SHALL have parameter NOP_VALUE, INSTR_W bits, default 32'h0000_0013 (addi x0,x0,0), which is the bubble instruction.
REQ-004 The block SHALL have parameter STALL_CNT_W, default 16, giving the stall counter width.
REQ-005 The block SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port flush  in  1  discards all held and incoming entries.
REQ-008 The block SHALL have port in_valid  in  1  upstream entry present.
REQ-009 The block SHALL have port in_ready  out  1  stage accepts an entry this cycle.
REQ-010 The block SHALL have port in_pc  in  PC_W  upstream PC.
REQ-011 The block SHALL have port in_instr  in  INSTR_W  upstream instruction.
REQ-012 The block SHALL have port out_valid  out  1  downstream entry present.
REQ-013 The block SHALL have port out_ready  in  1  downstream accepts.
REQ-014 The block SHALL have port out_pc  out  PC_W  held PC.
REQ-015 The block SHALL have port out_instr  out  INSTR_W  held instruction.
REQ-016 The block SHALL have port stall_cnt  out  STALL_CNT_W  back-pressure cycle count.

Function
REQ-017 Transfers SHALL follow these rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-018 Latency SHALL be 1 cycle, so an entry accepted at edge N is visible on out_* after edge N.
REQ-019 out_valid, out_pc and out_instr SHALL be registered, with no combinational path from in_* to out_*.
REQ-020 Whenever out_valid is 0, out_instr SHALL equal NOP_VALUE and out_pc SHALL equal 0.
REQ-021 When the stage empties by an output transfer with no refill, the payload SHALL be reloaded with NOP_VALUE/0.
REQ-022 flush SHALL have highest priority: at the next edge all valid bits clear and all payloads load NOP_VALUE/0.
REQ-023 An input transfer coinciding with flush SHALL be dropped.
REQ-024 An output transfer coinciding with flush SHALL still count as consumed downstream.
REQ-025 Entries SHALL leave in acceptance order, with no duplication and no loss except under flush.
REQ-026 stall_cnt SHALL increment by 1 on every edge where out_valid && !out_ready, saturate at all-ones, and be unaffected by flush.
REQ-027 PC_W and INSTR_W SHALL be independent; no truncation or extension of payload.

Reset
REQ-028 On rst_n low, asynchronously: out_valid=0, out_pc=0, out_instr=NOP_VALUE, stall_cnt=0, all internal valid/state cleared.
REQ-029 With PIPE_SKID_EN defined, in_ready SHALL be 0 while rst_n is low and SHALL be 1 from the first edge after deassertion.
REQ-030 Reset asserted mid-transfer SHALL discard the entry, with no partial update visible after release.

Configuration
REQ-031 With PIPE_SKID_EN undefined, the block SHALL be a single slot, with in_ready = !out_valid || out_ready, combinational from out_ready.
REQ-032 With PIPE_SKID_EN undefined, an input transfer and an output transfer in the same cycle SHALL replace the slot contents.
REQ-033 With PIPE_SKID_EN defined, the block SHALL have a main slot plus a skid slot, with states EMPTY, ONE and TWO.
REQ-034 With PIPE_SKID_EN defined, in_ready SHALL be registered and equal to (state != TWO).
REQ-035 EMPTY SHALL transition to ONE on an input transfer.
REQ-036 ONE SHALL transition to TWO on an input transfer without an output transfer, with the new entry placed in the skid slot.
REQ-037 ONE SHALL transition to EMPTY on an output transfer without an input transfer.
REQ-038 ONE SHALL stay in ONE, with the main slot replaced, on simultaneous input and output transfers.
REQ-039 TWO SHALL transition to ONE on an output transfer, moving the skid entry to the main slot.
REQ-040 flush SHALL take any state to EMPTY.
REQ-041 With PIPE_SKID_EN defined, the block SHALL sustain one transfer per cycle with out_ready toggling, and SHALL have no combinational path out_ready -> in_ready.

Structure
REQ-042 The shared package pipe_pkg SHALL hold the RV_NOP constant (32'h0000_0013) used as the NOP_VALUE default.
REQ-043 pipe_pkg SHALL hold the skid state typedef {EMPTY, ONE, TWO}.
REQ-044 One sub-module, pipe_skid_slot, SHALL hold the second entry and be instantiated only under PIPE_SKID_EN.

Verification
REQ-045 Reset scenario: assert rst_n=0 mid-stream -> out_valid=0, out_instr=32'h00000013, out_pc=0, stall_cnt=0 immediately, without waiting for a clock edge.
REQ-046 Streaming scenario: in_valid=1 and out_ready=1 every cycle, PCs 0x0,0x4,0x8 -> out_pc 0x0,0x4,0x8 on consecutive cycles, one cycle after entry.
REQ-047 Back-pressure scenario: out_ready=0 for 5 cycles while holding pc 0x100 -> out_pc stays 0x100 and stall_cnt=5; with PIPE_SKID_EN, a second entry 0x104 is accepted, then in_ready=0.
REQ-048 Flush scenario: flush=1 with an entry held and in_valid=1 (pc 0x200) -> next cycle out_valid=0, out_instr=32'h00000013, and 0x200 never appears.
REQ-049 Saturation scenario: STALL_CNT_W=4, 20 stall cycles -> stall_cnt=4'hF.
REQ-050 Random scenario: random in_valid/out_ready for 10k cycles, both macro settings -> output sequence equals the input sequence (scoreboard), with no stall_cnt wrap-around.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
//   RV_NOP       : bubble instruction (addi x0,x0,0), the default NOP_VALUE.
//   skid_state_e : occupancy of the two-entry variant (PIPE_SKID_EN builds).
package pipe_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Second (skid) storage slot of the pipeline stage register.
// Holds one PC/instruction pair; validity is tracked by the parent's state.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   load_i             : capture pc_i/instr_i at the next edge
//   clear_i            : reload 0/NOP_VALUE at the next edge (wins over load_i)
//   pc_i, instr_i      : incoming payload
//   pc_o, instr_o      : held payload
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned          PC_W      = 32,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_VALUE = INSTR_W'(RV_NOP)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            pc_d    = '0;
            instr_d = NOP_VALUE;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            instr_q <= NOP_VALUE;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying a PC and an instruction.
// Default build: single slot, in_ready = !out_valid || out_ready.
// With macro PIPE_SKID_EN defined: main slot plus skid slot, registered in_ready.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   flush                         : drop held and incoming entries
//   in_valid/in_ready/in_pc/in_instr     : upstream handshake and payload
//   out_valid/out_ready/out_pc/out_instr : downstream handshake and payload
//   stall_cnt                     : saturating count of out_valid && !out_ready edges
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        PC_W        = 32,
    parameter int unsigned        INSTR_W     = 32,
    parameter logic [INSTR_W-1:0] NOP_VALUE   = INSTR_W'(RV_NOP),
    parameter int unsigned        STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]     in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   main_valid_q, main_valid_d;
    logic [PC_W-1:0]        main_pc_q, main_pc_d;
    logic [INSTR_W-1:0]     main_instr_q, main_instr_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_valid_q && out_ready;

    // Counts back-pressure independently of flush; sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

`ifdef PIPE_SKID_EN

    skid_state_e        state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               skid_load;
    logic               skid_clear;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    assign in_ready = in_ready_q;

    always_comb begin
        state_d      = state_q;
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        if (flush) begin
            state_d      = EMPTY;
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_instr_d = NOP_VALUE;
            skid_clear   = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ONE;
                        main_valid_d = 1'b1;
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (!in_xfer && out_xfer) begin
                        state_d      = EMPTY;
                        main_valid_d = 1'b0;
                        main_pc_d    = '0;
                        main_instr_d = NOP_VALUE;
                    end else if (in_xfer && out_xfer) begin
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_xfer) begin
                        state_d      = ONE;
                        main_pc_d    = skid_pc;
                        main_instr_d = skid_instr;
                        skid_clear   = 1'b1;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    main_valid_d = 1'b0;
                    main_pc_d    = '0;
                    main_instr_d = NOP_VALUE;
                    skid_clear   = 1'b1;
                end
            endcase
        end
        // Registered ready breaks the out_ready -> in_ready path.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_skid_slot #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid_slot (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (in_pc),
        .instr_i (in_instr),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

`else

    assign in_ready = !main_valid_q || out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_instr_d = NOP_VALUE;
        end else if (in_xfer) begin
            // Also covers simultaneous in/out: the slot is replaced.
            main_valid_d = 1'b1;
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_pc_d    = '0;
            main_instr_d = NOP_VALUE;
        end
    end

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= NOP_VALUE;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (both PIPE_SKID_EN settings).
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [15:0] stall_cnt;

    logic        s_flush = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_instr;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .PC_W        (32),
        .INSTR_W     (32),
        .STALL_CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(
        .STALL_CNT_W (4)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_pc     (32'h0000_0abc),
        .in_instr  (32'h1234_5678),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_pc    (s_out_pc),
        .out_instr (s_out_instr),
        .stall_cnt (s_stall_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_ir;
        logic [15:0] e_stall;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    entry_t      q[$];
    int unsigned m_stall = 0;
    bit          armed = 1'b0;
    logic        m_ov;
    logic        m_ir;
    vec_t        tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Reference: FIFO of accepted entries, capacity 1 (or 2 with skid).
    task automatic model_check();
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        m_ov = (q.size() != 0);
        if (SKID) m_ir = armed && (q.size() < 2);
        else      m_ir = (q.size() == 0) || out_ready;
        if (m_ov) begin
            e_pc  = q[0].pc;
            e_ins = q[0].instr;
        end else begin
            e_pc  = '0;
            e_ins = NOP;
        end
        chk("model out_valid", out_valid, m_ov);
        chk("model out_pc", out_pc, e_pc);
        chk("model out_instr", out_instr, e_ins);
        chk("model in_ready", in_ready, m_ir);
        chk("model stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic advance();
        entry_t e;
        @(posedge clk);
        if (m_ov && !out_ready && m_stall != 32'hFFFF) m_stall++;
        if (m_ov && out_ready) void'(q.pop_front());
        if (in_valid && m_ir) begin
            e.pc    = in_pc;
            e.instr = in_instr;
            q.push_back(e);
        end
        if (flush) q.delete();
        armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        drive(iv, pc, ins, ordy, fl);
        model_check();
        advance();
    endtask

    task automatic do_reset();
        in_valid    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_instr", out_instr, NOP);
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset stall_cnt", stall_cnt, 16'h0);
        chk("reset in_ready", in_ready, SKID ? 1'b0 : 1'b1);
        q.delete();
        m_stall = 0;
        armed   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h0, 32'h0050_0093, 1'b1, 1'b0, 32'h0, NOP, 1'b1, 16'd0};
        tbl[1] = '{1'b1, 32'h4, 32'h00a0_0113, 1'b1, 1'b1, 32'h0, 32'h0050_0093, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 32'h8, 32'h00f0_0193, 1'b1, 1'b1, 32'h4, 32'h00a0_0113, 1'b1, 16'd0};
        tbl[3] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h00f0_0193, 1'b1, 16'd0};
        tbl[4] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, NOP, 1'b1, 16'd0};

        do_reset();
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming table: PCs 0,4,8 appear one cycle after entry.
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].ordy, 1'b0);
            model_check();
            chk($sformatf("tbl[%0d] out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl[%0d] out_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("tbl[%0d] out_instr", i), out_instr, tbl[i].e_instr);
            chk($sformatf("tbl[%0d] in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl[%0d] stall_cnt", i), stall_cnt, tbl[i].e_stall);
            advance();
        end

        // Back-pressure: hold 0x100 for 5 stalled edges.
        cycle(1'b1, 32'h100, 32'h1111_0001, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 32'h104, 32'h1111_0002, 1'b0, 1'b0);
        chk("bp out_pc held", out_pc, 32'h100);
        chk("bp out_valid", out_valid, 1'b1);
        chk("bp stall_cnt", stall_cnt, 16'd5);
        chk("bp in_ready", in_ready, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp drain out_valid", out_valid, SKID ? 1'b1 : 1'b0);
        chk("bp drain out_pc", out_pc, SKID ? 32'h104 : 32'h0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp empty out_valid", out_valid, 1'b0);
        chk("bp empty out_instr", out_instr, NOP);

        // Flush with an entry held and a new one offered.
        cycle(1'b1, 32'h1f0, 32'h2222_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h200, 32'h2222_0002, 1'b0, 1'b1);
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush out_instr", out_instr, NOP);
        chk("flush out_pc", out_pc, 32'h0);
        chk("flush stall_cnt", stall_cnt, 16'd6);
        repeat (3) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk("flush 0x200 never appears", out_valid, 1'b0);
        end

        // Reset asserted mid-stream.
        cycle(1'b1, 32'h300, 32'h3333_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'h3333_0002, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("post-reset out_valid", out_valid, 1'b0);
        chk("post-reset in_ready", in_ready, 1'b1);

        // Random traffic against the FIFO model.
        for (int i = 0; i < 10000; i++) begin
            cycle(logic'($urandom_range(0, 99) < 70), $urandom, $urandom,
                  logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 49) == 0));
        end
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("random drained", out_valid, 1'b0);

        // Saturation on the 4-bit counter instance.
        s_in_valid  = 1'b1;
        s_out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("sat stall_cnt at 14", s_stall_cnt, 4'hE);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("sat stall_cnt at 20", s_stall_cnt, 4'hF);
        chk("sat out_valid", s_out_valid, 1'b1);
        chk("sat out_pc", s_out_pc, 32'h0000_0abc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
